// File: rtl/burst_ram_pkg.sv
// burst_ram_pkg
//   Shared constants and types for the burst RAM and the cache's column decode.
//   A cache line is BURST_LENGTH 32-bit words; byte address bits [3:0] select
//   a byte within the line (ZEROS_BITWIDTH byte-in-word bits plus
//   COLUMN_IX_BITWIDTH word-in-line bits). The line index starts at LINE_LSB.
package burst_ram_pkg;

  localparam int BURST_LENGTH       = 4;
  localparam int COLUMN_IX_BITWIDTH = 2;
  localparam int ZEROS_BITWIDTH     = 2;
  localparam int LINE_LSB           = COLUMN_IX_BITWIDTH + ZEROS_BITWIDTH;

  typedef logic [COLUMN_IX_BITWIDTH-1:0] column_t;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    READ_WAIT   = 2'd1,
    READ_BURST  = 2'd2,
    WRITE_BURST = 2'd3
  } state_e;

endpackage

// File: rtl/burst_ram_if.sv
// burst_ram_if
//   Bus between the cache controller (master) and the burst RAM (slave).
//   Signals:
//     cmd_valid/cmd_ready/cmd_write/cmd_address : burst command
//     wr_data/wr_valid/wr_ready                 : write beats
//     rd_data/rd_valid                          : read beats (no backpressure)
//     busy                                      : slave is not idle
//
//   Handshake rules: a transfer on cmd_* or wr_* happens on a rising clk edge
//   where both valid and ready are high; the master may raise valid at any
//   time and must not assume a transfer until ready is seen high at that edge;
//   ready never depends combinationally on valid. rd_valid is a pure
//   strobe: the master must take each beat on the cycle it is presented.
interface burst_ram_if;
  import burst_ram_pkg::*;

  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_address;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        busy;

  modport master (
    output cmd_valid, cmd_write, cmd_address, wr_data, wr_valid,
    input  cmd_ready, wr_ready, rd_data, rd_valid, busy
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_address, wr_data, wr_valid,
    output cmd_ready, wr_ready, rd_data, rd_valid, busy
  );

endinterface

// File: rtl/burst_ram_store.sv
// burst_ram_store
//   Single-port synchronous word RAM, depth 2**ADDR_W, 32-bit words.
//   Ports:
//     clk   : clock
//     we    : write enable, writes wdata at addr on the rising edge
//     addr  : word address ({line, column} from the burst FSM)
//     wdata : write data
//     rdata : registered read data of addr from the previous edge
//   No reset on the array or the output register so the tools map it onto
//   block RAM; contents are undefined until written.
module burst_ram_store #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [0:(1<<ADDR_W)-1];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/burst_ram.sv
// burst_ram
//   Backing memory for the direct-mapped data cache. Serves 4-word read
//   bursts (line fills) and accepts 4-word write bursts (write-backs), with a
//   programmable read latency that emulates external SDRAM.
//   Parameters:
//     ADDRESS_BITWIDTH : line-index bits; capacity 2**ADDRESS_BITWIDTH lines
//     READ_LATENCY     : wait cycles from command to first read beat (1..15)
//   Ports:
//     clk       : clock, all state on the rising edge
//     rst       : asynchronous, active-high reset
//     bus       : burst_ram_if slave (command, write beats, read beats, busy)
//     dbg_state : current FSM state, for observation only
module burst_ram
  import burst_ram_pkg::*;
#(
  parameter int ADDRESS_BITWIDTH = 10,
  parameter int READ_LATENCY     = 2
) (
  input  logic           clk,
  input  logic           rst,
  burst_ram_if.slave     bus,
  output state_e         dbg_state
);

  localparam int         RAM_AW    = ADDRESS_BITWIDTH + COLUMN_IX_BITWIDTH;
  localparam logic [3:0] LAT_LAST  = 4'(READ_LATENCY);
  localparam logic [3:0] LAT_ISSUE = 4'(READ_LATENCY - 1);
  localparam logic [2:0] BEATS     = 3'(BURST_LENGTH);
  localparam logic [2:0] LAST_BEAT = 3'(BURST_LENGTH - 1);

  state_e                      state_q, state_d;
  logic [ADDRESS_BITWIDTH-1:0] line_q, line_d;
  logic [3:0]                  lat_q, lat_d;
  column_t                     col_q, col_d;
  logic [2:0]                  beat_q, beat_d;
  logic                        rd_valid_q, rd_valid_d;
  logic [31:0]                 rd_data_q, rd_data_d;

  logic                        ram_we;
  column_t                     ram_col;
  logic [31:0]                 ram_rdata;

  // Byte offset and the bits above the line index do not select storage;
  // addresses simply wrap modulo the capacity.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.cmd_address[LINE_LSB-1:0],
                              bus.cmd_address[31:LINE_LSB+ADDRESS_BITWIDTH]};

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    lat_d   = lat_q;
    col_d   = col_q;
    beat_d  = beat_q;
    ram_we  = 1'b0;
    ram_col = col_q;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          line_d  = bus.cmd_address[LINE_LSB +: ADDRESS_BITWIDTH];
          lat_d   = '0;
          col_d   = '0;
          beat_d  = '0;
          state_d = bus.cmd_write ? WRITE_BURST : READ_WAIT;
        end
      end

      // Stays READ_LATENCY+1 cycles. The RAM read for column 0 goes out on
      // the edge that ends wait cycle READ_LATENCY-1, and the column address
      // keeps advancing from then on, so the RAM output is always one column
      // ahead of the registered rd_data.
      READ_WAIT: begin
        lat_d = lat_q + 4'd1;
        if (lat_q >= LAT_ISSUE) begin
          col_d = col_q + column_t'(1);
        end
        if (lat_q == LAT_LAST) begin
          lat_d   = '0;
          state_d = READ_BURST;
        end
      end

      READ_BURST: begin
        col_d  = col_q + column_t'(1);
        beat_d = beat_q + 3'd1;
        if (beat_q == LAST_BEAT) begin
          col_d   = '0;
          beat_d  = '0;
          state_d = IDLE;
        end
      end

      // beat_q == BEATS is a one-cycle tail after the last beat: wr_ready is
      // already low and the state returns to IDLE at the following edge.
      WRITE_BURST: begin
        ram_col = beat_q[COLUMN_IX_BITWIDTH-1:0];
        if (beat_q == BEATS) begin
          beat_d  = '0;
          state_d = IDLE;
        end else if (bus.wr_valid) begin
          ram_we = 1'b1;
          beat_d = beat_q + 3'd1;
        end
      end

      default: state_d = IDLE;
    endcase

    rd_valid_d = (state_d == READ_BURST);
    rd_data_d  = rd_valid_d ? ram_rdata : rd_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      line_q     <= '0;
      lat_q      <= '0;
      col_q      <= '0;
      beat_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      lat_q      <= lat_d;
      col_q      <= col_d;
      beat_q     <= beat_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  burst_ram_store #(
    .ADDR_W (RAM_AW)
  ) u_store (
    .clk   (clk),
    .we    (ram_we),
    .addr  ({line_q, ram_col}),
    .wdata (bus.wr_data),
    .rdata (ram_rdata)
  );

  // cmd_ready is gated by rst so it drops the moment reset is asserted.
  assign bus.cmd_ready = (state_q == IDLE) && !rst;
  assign bus.wr_ready  = (state_q == WRITE_BURST) && (beat_q != BEATS);
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.busy      = (state_q != IDLE);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_burst_ram.sv
// tb_burst_ram
//   Self-checking bench for burst_ram (ADDRESS_BITWIDTH=10, READ_LATENCY=2).
//   Write bursts update a line-indexed reference memory; read commands push
//   the four expected words onto exp_q, and a monitor pops one per rd_valid.
module tb_burst_ram;
  import burst_ram_pkg::*;

  localparam int AW  = 10;
  localparam int LAT = 2;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst = 1'b0;
  state_e dbg_state;

  always #5 clk = ~clk;

  burst_ram_if bus();

  burst_ram #(
    .ADDRESS_BITWIDTH (AW),
    .READ_LATENCY     (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model [int];
  logic [31:0] wbuf [4];
  logic [31:0] rand_addr [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic int line_of(input logic [31:0] addr);
    return int'((addr >> 4) & ((32'd1 << AW) - 32'd1));
  endfunction

  always @(negedge clk) begin
    if (bus.rd_valid) begin
      if (exp_q.size() == 0) begin
        check("rd_extra_beat", 32'(bus.rd_valid), 32'd0);
      end else begin
        check("rd_data", bus.rd_data, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Asserts rst at the caller's time, checks outputs clear at once, holds it
  // for two negedges and releases mid-cycle.
  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    bus.wr_valid  = 1'b0;
    bus.cmd_valid = 1'b0;
    #1;
    check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
    check({tag, "_wr_ready"},  32'(bus.wr_ready),  32'd0);
    check({tag, "_rd_valid"},  32'(bus.rd_valid),  32'd0);
    check({tag, "_rd_data"},   bus.rd_data,        32'd0);
    check({tag, "_busy"},      32'(bus.busy),      32'd0);
    check({tag, "_state"},     32'(dbg_state),     32'(IDLE));
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check({tag, "_release_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    @(negedge clk);
    check({tag, "_after_edge_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    check({tag, "_after_edge_busy"},      32'(bus.busy),      32'd0);
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("cmd_ready_wait", 32'(bus.cmd_ready), 32'd1);
  endtask

  // pat[i] is wr_valid on step i for i < pat_len, then wr_valid stays high.
  // stop_after < 4 asserts reset mid-cycle after that many beats.
  task automatic do_write(input logic [31:0] addr, input logic [7:0] pat,
                          input int pat_len, input int stop_after);
    bit ok;
    int idx  = 0;
    int step = 0;
    int ln   = line_of(addr);
    @(posedge clk); #1;
    bus.cmd_valid   = 1'b1;
    bus.cmd_write   = 1'b1;
    bus.cmd_address = addr;
    wait_ready(ok);
    if (!ok) begin
      bus.cmd_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.cmd_valid   = 1'b0;
    bus.cmd_write   = 1'b0;
    bus.cmd_address = $urandom;
    while (idx < 4 && step < 64) begin
      bus.wr_valid = (step < pat_len) ? pat[step] : 1'b1;
      bus.wr_data  = bus.wr_valid ? wbuf[idx] : $urandom;
      @(negedge clk);
      check("wr_ready", 32'(bus.wr_ready), 32'd1);
      @(posedge clk);
      if (bus.wr_valid) begin
        model[ln*4 + idx] = wbuf[idx];
        idx++;
      end
      step++;
      if (stop_after < 4 && idx == stop_after) begin
        #4;
        pulse_reset("wr_rst");
        return;
      end
      #1;
    end
    bus.wr_valid = 1'b0;
    check("wr_beat_count", 32'(idx), 32'd4);
    @(negedge clk);
    check("wr_tail_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("wr_tail_wr_ready",  32'(bus.wr_ready),  32'd0);
    check("wr_tail_busy",      32'(bus.busy),      32'd1);
    @(negedge clk);
    check("wr_done_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("wr_done_busy",      32'(bus.busy),      32'd0);
  endtask

  // probe holds a second read command during the burst; reset_at >= 0 asserts
  // reset in the cycle after edge E+reset_at.
  task automatic do_read(input logic [31:0] addr, input bit probe, input int reset_at);
    bit ok;
    int ln = line_of(addr);
    @(posedge clk); #1;
    bus.cmd_valid   = 1'b1;
    bus.cmd_write   = 1'b0;
    bus.cmd_address = addr;
    wait_ready(ok);
    if (!ok) begin
      bus.cmd_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.cmd_valid   = 1'b0;
    bus.cmd_address = $urandom;
    for (int c = 0; c < 4; c++) exp_q.push_back(model[ln*4 + c]);
    for (int k = 0; k <= LAT + 5; k++) begin
      @(negedge clk);
      check($sformatf("rd_valid@E+%0d", k),  32'(bus.rd_valid),  32'(k >= LAT + 1 && k <= LAT + 4));
      check($sformatf("cmd_ready@E+%0d", k), 32'(bus.cmd_ready), 32'(k == LAT + 5));
      check($sformatf("busy@E+%0d", k),      32'(bus.busy),      32'(k != LAT + 5));
      if (probe) begin
        bus.cmd_valid   = (k <= LAT + 3);
        bus.cmd_address = 32'h0000_2040;
      end
      if (k == reset_at) begin
        #2;
        pulse_reset("rd_rst");
        exp_q.delete();
        break;
      end
    end
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rd_quiet", 32'(bus.rd_valid), 32'd0);
    end
    if (reset_at < 0) check("rd_beats_consumed", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.cmd_valid   = 1'b0;
    bus.cmd_write   = 1'b0;
    bus.cmd_address = '0;
    bus.wr_data     = '0;
    bus.wr_valid    = 1'b0;

    // Reset asserted mid-cycle, outputs must clear at once.
    repeat (2) @(posedge clk);
    #3;
    pulse_reset("init");

    // Write then read, back-to-back beats.
    wbuf = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    do_write(32'h0000_1000, 8'h00, 0, 4);
    do_read(32'h0000_1000, 1'b0, -1);

    // Write with wr_valid gaps 1,0,1,1,0,0,1.
    wbuf = '{32'hD0, 32'hD1, 32'hD2, 32'hD3};
    do_write(32'h0000_2040, 8'h4D, 7, 4);
    do_read(32'h0000_2040, 1'b0, -1);

    // Address wrap and line alignment.
    wbuf = '{32'hE0, 32'hE1, 32'hE2, 32'hE3};
    do_write(32'h0000_0010, 8'h00, 0, 4);
    do_read(32'h0000_4010, 1'b0, -1);
    do_read(32'h0000_401C, 1'b0, -1);

    // Command offered during a read burst is ignored.
    do_read(32'h0000_1000, 1'b1, -1);

    // Reset after two write beats keeps only those two.
    wbuf = '{32'hC0, 32'hC1, 32'hC2, 32'hC3};
    do_write(32'h0000_3000, 8'h00, 0, 4);
    wbuf = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
    do_write(32'h0000_3000, 8'h00, 0, 2);
    do_read(32'h0000_3000, 1'b0, -1);

    // Reset in the middle of a read burst, then a clean read.
    do_read(32'h0000_2040, 1'b0, LAT + 2);
    do_read(32'h0000_2040, 1'b0, -1);

    // Random lines, data and gap patterns.
    for (int i = 0; i < 4; i++) begin
      rand_addr[i] = (32'(i * 97 + 5) << 4) | 32'($urandom_range(0, 15));
      for (int c = 0; c < 4; c++) wbuf[c] = $urandom;
      do_write(rand_addr[i], 8'($urandom_range(0, 255)), $urandom_range(0, 8), 4);
    end
    for (int i = 3; i >= 0; i--) do_read(rand_addr[i], 1'b0, -1);

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no completion, expected end of test before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
